drp_master_10g: RTL
===================

// Module: drp_master_10g
//
// PURPOSE
//   Initiator for the transceiver DRP port shared with the 10G PCS/PMA core.
//   Accepts single read/write commands from control logic and runs the
//   req/gnt arbitration handshake with the PCS/PMA core.
//   Issues the one-cycle DRP strobe, waits for drdy with a timeout, and
//   returns read data or a timeout flag over a valid/ready response channel.
//   Sits between the register/control plane and the drp_req/drp_gnt/drp_*_i
//   ports of the PCS/PMA core, all on dclk.
//
// PARAMETERS
//   ADDR_W       16   DRP address width
//   GNT_TIMEOUT  256  dclk cycles to wait for drp_gnt before abort (>=2)
//   RDY_TIMEOUT  64   dclk cycles to wait for drp_drdy after strobe (>=2)
//
// PORTS
//   dclk         in   1       DRP clock; all logic on its rising edge
//   rst          in   1       synchronous active-high reset
//   cmd_valid    in   1       command present
//   cmd_ready    out  1       command accepted when cmd_valid&&cmd_ready
//   cmd_write    in   1       1=write, 0=read
//   cmd_addr     in   ADDR_W  DRP address
//   cmd_wdata    in   16      write data
//   rsp_valid    out  1       response present; held until rsp_ready
//   rsp_ready    in   1       response consumer ready
//   rsp_rdata    out  16      read data (0 for writes and timeouts)
//   rsp_timeout  out  1       1 = gnt or drdy timed out, no DRP data
//   drp_req      out  1       request ownership of the DRP port
//   drp_gnt      in   1       ownership granted
//   drp_den      out  1       DRP enable strobe, exactly 1 cycle per access
//   drp_dwe      out  1       DRP write enable, qualified by drp_den
//   drp_daddr    out  ADDR_W  DRP address, qualified by drp_den
//   drp_di       out  16      DRP write data, qualified by drp_den&&drp_dwe
//   drp_drdy     in   1       DRP access complete
//   drp_drpdo    in   16      DRP read data, valid with drp_drdy
//   busy         out  1       1 in every state except IDLE
//
// BEHAVIOUR
//   Reset: state=IDLE; cmd_ready, rsp_valid, rsp_timeout, drp_req, drp_den,
//     drp_dwe, busy = 0; rsp_rdata, drp_daddr, drp_di = 0; counter = 0.
//     Reset asserted mid-transaction aborts immediately; no response is issued.
//   cmd_ready = (state==IDLE) && !rst. On accept, latch write/addr/wdata and
//     enter REQ.
//   FSM: IDLE -> REQ -> STROBE -> WAIT -> RESP -> IDLE.
//   REQ: drp_req=1 (first high the cycle after accept).
//     - drp_gnt sampled high: go to STROBE.
//     - counter reaches GNT_TIMEOUT-1 without gnt: go to RESP with
//       timeout=1 and rdata=0.
//   STROBE: one cycle with drp_den=1, drp_dwe=latched write, drp_daddr and
//     drp_di from the latch; then WAIT. drp_den is 0 in all other states.
//     drp_dwe, drp_daddr and drp_di return to 0 when drp_den=0.
//   WAIT: drp_req stays 1.
//     - drp_drdy high: capture drp_drpdo (reads) or 0 (writes); go to RESP
//       with timeout=0.
//     - RDY_TIMEOUT cycles elapse without drdy: go to RESP with timeout=1,
//       rdata=0.
//   RESP: drp_req=0; rsp_valid=1 with rdata/timeout stable until rsp_ready.
//     On rsp_valid&&rsp_ready, go to IDLE; rsp_valid drops the next cycle.
//   Latency, no stalls: accept@0, drp_req@1, gnt@1 -> den@2, drdy@k ->
//     rsp_valid@k+1. Back-to-back commands: cmd_ready reasserts the cycle
//     after the response handshake.
//   drp_drdy outside WAIT is ignored, including the STROBE cycle. A late
//     drdy after a timeout is ignored.
//   drp_gnt outside REQ is ignored. Gnt withdrawn in STROBE or WAIT does not
//     abort the access.
//   Counter: clog2(max(GNT_TIMEOUT,RDY_TIMEOUT))+1 bits; cleared on each
//     state entry; saturates and never wraps.
//
// TESTING
//   Read, gnt@+1, drdy 3 cycles after den, drpdo=16'hBEEF -> one den pulse with
//     dwe=0 and addr latched; rsp_rdata=16'hBEEF, rsp_timeout=0.
//   Write addr=16'h0044, data=16'h1234 -> den&&dwe for 1 cycle with di=16'h1234;
//     rsp_rdata=0, rsp_timeout=0.
//   gnt never asserted -> exactly GNT_TIMEOUT cycles of drp_req, no den;
//     rsp_timeout=1, rsp_rdata=0.
//   drdy never asserted -> rsp_timeout=1 after RDY_TIMEOUT cycles; a drdy
//     injected 10 cycles later changes nothing.
//   rsp_ready held low 20 cycles -> rsp_valid and data stable, cmd_ready=0,
//     no new DRP activity.
//   rst pulsed in WAIT -> all outputs 0 next cycle; no rsp_valid; next command
//     completes normally.

Source files
------------

// File: rtl/drp_master_10g.sv
// rtl/drp_master_10g.sv - DRP initiator with req/gnt arbitration, drdy timeout and response channel
module drp_master_10g #(
    parameter int ADDR_W      = 16,
    parameter int GNT_TIMEOUT = 256,
    parameter int RDY_TIMEOUT = 64
) (
    input  logic              dclk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [15:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_timeout,
    output logic              drp_req,
    input  logic              drp_gnt,
    output logic              drp_den,
    output logic              drp_dwe,
    output logic [ADDR_W-1:0] drp_daddr,
    output logic [15:0]       drp_di,
    input  logic              drp_drdy,
    input  logic [15:0]       drp_drpdo,
    output logic              busy
);

    localparam int MAX_TO = (GNT_TIMEOUT > RDY_TIMEOUT) ? GNT_TIMEOUT : RDY_TIMEOUT;
    localparam int CNT_W  = $clog2(MAX_TO) + 1;
    localparam logic [CNT_W-1:0] GNT_LAST = CNT_W'(GNT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RDY_LAST = CNT_W'(RDY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        STROBE = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic              cap;
    logic              cap_to;
    logic [15:0]       cap_data;

    always_comb begin
        state_d  = state;
        cap      = 1'b0;
        cap_to   = 1'b0;
        cap_data = 16'h0000;
        case (state)
            IDLE: begin
                if (cmd_valid) state_d = REQ;
            end
            REQ: begin
                if (drp_gnt) begin
                    state_d = STROBE;
                end else if (cnt == GNT_LAST) begin
                    state_d = RESP;
                    cap     = 1'b1;
                    cap_to  = 1'b1;
                end
            end
            STROBE: state_d = WAIT;
            WAIT: begin
                // drdy wins over a timeout landing in the same cycle
                if (drp_drdy) begin
                    state_d  = RESP;
                    cap      = 1'b1;
                    cap_data = write_q ? 16'h0000 : drp_drpdo;
                end else if (cnt == RDY_LAST) begin
                    state_d = RESP;
                    cap     = 1'b1;
                    cap_to  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge dclk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 16'h0000;
            rsp_rdata   <= 16'h0000;
            rsp_timeout <= 1'b0;
        end else begin
            state <= state_d;
            // cleared on every state entry; saturates rather than wrapping
            if (state_d != state) begin
                cnt <= '0;
            end else if (cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
            if (state == IDLE && cmd_valid) begin
                write_q <= cmd_write;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            if (cap) begin
                rsp_rdata   <= cap_data;
                rsp_timeout <= cap_to;
            end else if (state == RESP && rsp_ready) begin
                rsp_rdata   <= 16'h0000;
                rsp_timeout <= 1'b0;
            end
        end
    end

    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign drp_req   = (state == REQ) || (state == STROBE) || (state == WAIT);
    assign drp_den   = (state == STROBE);
    assign drp_dwe   = drp_den && write_q;
    assign drp_daddr = drp_den ? addr_q : '0;
    assign drp_di    = (drp_den && write_q) ? wdata_q : 16'h0000;

endmodule
